// File: rtl/mul_fp16_pkg.sv
// Shared types and constants for the FP16 multiplier issuer.
// Imported by the result FIFO and the issuer top level.
package mul_fp16_pkg;

  localparam int FP16_W = 16;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } issuer_state_t;

  typedef struct packed {
    logic              last;
    logic [FP16_W-1:0] data;
  } fp16_res_t;

endpackage

// File: rtl/fp16_result_fifo.sv
// Synchronous result FIFO; pointers wrap explicitly so any depth works.
// Push and pop in the same cycle are accepted even when full.
module fp16_result_fifo
  import mul_fp16_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          nRST,
  input  logic          push,
  input  fp16_res_t     push_data,
  input  logic          pop,
  output fp16_res_t     pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  fp16_res_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] wrap_inc(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wrap_inc(wr_ptr);
      if (do_pop)
        rd_ptr <= wrap_inc(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mul_fp16_issuer.sv
// Issue/collect front end for the pipelined FP16 multiplier.
// Credits keep every returned product room in the output FIFO.
module mul_fp16_issuer
  import mul_fp16_pkg::*;
#(
  parameter int OUT_DEPTH   = 4,
  parameter int MUL_LATENCY = 2
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP16_W-1:0] in_a,
  input  logic [FP16_W-1:0] in_b,
  input  logic              in_last,
  output logic              mul_start,
  output logic [FP16_W-1:0] mul_a,
  output logic [FP16_W-1:0] mul_b,
  input  logic [FP16_W-1:0] mul_result,
  input  logic              mul_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP16_W-1:0] out_result,
  output logic              out_last,
  input  logic              flush,
  output logic              flush_done,
  output logic              err,
  output logic [2:0]        inflight
);

  localparam int         CW   = $clog2(OUT_DEPTH + 1);
  localparam logic [1:0] MASK = 2'(MUL_LATENCY);

  issuer_state_t          state;
  logic [MUL_LATENCY-1:0] tag_v;
  logic [MUL_LATENCY-1:0] tag_l;
  logic [1:0]             mask_cnt;
  logic [CW-1:0]          occ;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic                   exit_v;
  logic                   exit_l;
  logic                   done_ok;
  logic                   credit_ok;
  fp16_res_t              push_data;
  fp16_res_t              pop_data;

  // Pops free credit only once occ has updated, keeping out_ready off in_ready.
  assign credit_ok = (32'(occ) + 32'(inflight)) < 32'(OUT_DEPTH);
  assign in_ready  = nRST & (state == RUN) & credit_ok;
  assign mul_start = in_valid & in_ready;
  assign mul_a     = in_a;
  assign mul_b     = in_b;

  assign exit_v  = tag_v[MUL_LATENCY-1];
  assign exit_l  = tag_l[MUL_LATENCY-1];
  // Stale products from before a reset land while the mask is nonzero.
  assign done_ok = mul_done & (mask_cnt == '0);
  assign push    = done_ok & (exit_v | ~full);

  assign push_data = '{last: exit_l, data: mul_result};

  assign out_valid  = ~empty;
  assign pop        = out_valid & out_ready;
  assign out_result = pop_data.data;
  assign out_last   = pop_data.last;

  fp16_result_fifo #(
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .nRST      (nRST),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .count     (occ)
  );

  always_ff @(posedge clk) begin
    if (!nRST) begin
      tag_v    <= '0;
      tag_l    <= '0;
      inflight <= '0;
      err      <= 1'b0;
      mask_cnt <= MASK;
    end else begin
      tag_v <= {tag_v[MUL_LATENCY-2:0], mul_start};
      tag_l <= {tag_l[MUL_LATENCY-2:0], in_last};
      if (mul_start & ~exit_v)
        inflight <= inflight + 3'd1;
      else if (~mul_start & exit_v)
        inflight <= inflight - 3'd1;
      if (exit_v != done_ok)
        err <= 1'b1;
      if (mask_cnt != '0)
        mask_cnt <= mask_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state      <= RUN;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      unique case (state)
        RUN: begin
          if (flush)
            state <= DRAIN;
        end
        DRAIN: begin
          if (inflight == '0 && empty) begin
            state      <= DONE;
            flush_done <= 1'b1;
          end
        end
        DONE: begin
          state <= RUN;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule
